// File: rtl/tlb_entry_ctrl.sv
// 8-entry instruction TLB store with fill / single-page invalidate / full-flush FSM.
// Fill and invalidate ack one cycle after the request is sampled in IDLE, flush acks after 8 cycles; busy holds off fetch meanwhile.
module tlb_entry_ctrl #(
    parameter int N_ENT = 8,
    parameter int ENT_W = 44,
    parameter int VPN_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_req,
    input  logic [VPN_W-1:0]         fill_vpn,
    input  logic [VPN_W-1:0]         fill_pfn,
    input  logic                     fill_present,
    input  logic                     fill_rw,
    input  logic                     fill_pcd,
    output logic                     fill_ack,
    input  logic                     invp_req,
    input  logic [VPN_W-1:0]         invp_vpn,
    output logic                     invp_ack,
    input  logic                     flush_req,
    output logic                     flush_ack,
    output logic                     busy,
    output logic [N_ENT*ENT_W-1:0]   TLB
);

    localparam int IDX_W = $clog2(N_ENT);
    localparam int V_BIT = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_INVP  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]                      state;
    logic [N_ENT-1:0][ENT_W-1:0]     tlb_q;
    logic [IDX_W-1:0]                rr_ptr;
    logic [IDX_W-1:0]                flush_idx;

    logic                            hit_found;
    logic [IDX_W-1:0]                hit_idx;
    logic                            free_found;
    logic [IDX_W-1:0]                free_idx;
    logic [IDX_W-1:0]                victim;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (tlb_q[i][V_BIT] && (tlb_q[i][ENT_W-1 -: VPN_W] == fill_vpn)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (!tlb_q[i][V_BIT]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        if (hit_found)
            victim = hit_idx;
        else if (free_found)
            victim = free_idx;
        else
            victim = rr_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tlb_q     <= '0;
            rr_ptr    <= '0;
            flush_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        state     <= S_FLUSH;
                        flush_idx <= '0;
                    end else if (invp_req) begin
                        state <= S_INVP;
                    end else if (fill_req) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    tlb_q[victim] <= {fill_vpn, fill_pfn, 1'b1, fill_present, fill_rw, fill_pcd};
                    if (!hit_found && !free_found)
                        rr_ptr <= rr_ptr + 1'b1;
                    state <= S_IDLE;
                end
                S_INVP: begin
                    for (int i = 0; i < N_ENT; i++) begin
                        if (tlb_q[i][ENT_W-1 -: VPN_W] == invp_vpn)
                            tlb_q[i][V_BIT] <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                S_FLUSH: begin
                    tlb_q[flush_idx][V_BIT] <= 1'b0;
                    flush_idx <= flush_idx + 1'b1;
                    if (flush_idx == LAST_IDX) begin
                        rr_ptr <= '0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fill_ack  = (state == S_FILL);
    assign invp_ack  = (state == S_INVP);
    assign flush_ack = (state == S_FLUSH) && (flush_idx == LAST_IDX);
    assign busy      = (state != S_IDLE);
    assign TLB       = tlb_q;

endmodule

// File: tb/tb_tlb_entry_ctrl.sv
// Bench for tlb_entry_ctrl: directed vector table, corner sequences, and random ops against an array model.
module tb_tlb_entry_ctrl;

    localparam int OP_FILL  = 0;
    localparam int OP_INVP  = 1;
    localparam int OP_FLUSH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fill_req = 1'b0;
    logic [19:0]  fill_vpn = '0;
    logic [19:0]  fill_pfn = '0;
    logic         fill_present = 1'b0;
    logic         fill_rw = 1'b0;
    logic         fill_pcd = 1'b0;
    logic         fill_ack;
    logic         invp_req = 1'b0;
    logic [19:0]  invp_vpn = '0;
    logic         invp_ack;
    logic         flush_req = 1'b0;
    logic         flush_ack;
    logic         busy;
    logic [351:0] TLB;

    int checks = 0;
    int errors = 0;

    tlb_entry_ctrl dut (
        .clk(clk), .rst(rst),
        .fill_req(fill_req), .fill_vpn(fill_vpn), .fill_pfn(fill_pfn),
        .fill_present(fill_present), .fill_rw(fill_rw), .fill_pcd(fill_pcd),
        .fill_ack(fill_ack),
        .invp_req(invp_req), .invp_vpn(invp_vpn), .invp_ack(invp_ack),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .busy(busy), .TLB(TLB)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays of fields plus a replacement pointer.
    logic [19:0] m_vpn [8];
    logic [19:0] m_pfn [8];
    logic        m_val [8];
    logic [2:0]  m_flg [8];
    int          m_rr;

    function automatic logic [351:0] model_tlb();
        logic [351:0] w = '0;
        for (int i = 0; i < 8; i++)
            w[44*i +: 44] = {m_vpn[i], m_pfn[i], m_val[i], m_flg[i]};
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_vpn[i] = '0; m_pfn[i] = '0; m_val[i] = 1'b0; m_flg[i] = '0;
        end
        m_rr = 0;
    endfunction

    function automatic int model_fill(logic [19:0] vpn, logic [19:0] pfn, logic [2:0] flg);
        int v = -1;
        for (int i = 0; i < 8; i++)
            if (v < 0 && m_val[i] && m_vpn[i] == vpn) v = i;
        for (int i = 0; i < 8; i++)
            if (v < 0 && !m_val[i]) v = i;
        if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % 8;
        end
        m_vpn[v] = vpn; m_pfn[v] = pfn; m_val[v] = 1'b1; m_flg[v] = flg;
        return v;
    endfunction

    function automatic void model_invp(logic [19:0] vpn);
        for (int i = 0; i < 8; i++)
            if (m_vpn[i] == vpn) m_val[i] = 1'b0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 8; i++) m_val[i] = 1'b0;
        m_rr = 0;
    endfunction

    task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_ack(int op);
        if (op == OP_FILL) return fill_ack;
        if (op == OP_INVP) return invp_ack;
        return flush_ack;
    endfunction

    // Steps one cycle at a time until the ack for op is seen; lat=-1 on timeout.
    task automatic wait_ack(input int op, input int max_cyc, output int lat, output int busy_cyc);
        lat = -1;
        busy_cyc = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (get_ack(op)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_op(input int op, input logic [19:0] vpn, input logic [19:0] pfn,
                         input logic [2:0] flg, input int exp_idx, input string tag);
        int lat, bc, idx, exp_lat;
        exp_lat = (op == OP_FLUSH) ? 8 : 1;
        if (op == OP_FILL) begin
            fill_vpn = vpn; fill_pfn = pfn;
            {fill_present, fill_rw, fill_pcd} = flg;
            fill_req = 1'b1;
        end else if (op == OP_INVP) begin
            invp_vpn = vpn; invp_req = 1'b1;
        end else begin
            flush_req = 1'b1;
        end
        wait_ack(op, 20, lat, bc);
        check({tag, "_ack_latency"}, 352'(lat), 352'(exp_lat));
        check({tag, "_busy_cycles"}, 352'(bc), 352'(exp_lat));
        @(posedge clk); #1;
        fill_req = 1'b0; invp_req = 1'b0; flush_req = 1'b0;
        if (op == OP_FILL) begin
            idx = model_fill(vpn, pfn, flg);
            if (exp_idx >= 0)
                check({tag, "_victim_word"}, 352'(TLB[44*exp_idx +: 44]), 352'({vpn, pfn, 1'b1, flg}));
        end else if (op == OP_INVP) begin
            model_invp(vpn);
            if (exp_idx >= 0)
                check({tag, "_valid_cleared"}, 352'(TLB[44*exp_idx + 3]), 352'(0));
        end else begin
            model_flush();
        end
        check({tag, "_tlb"}, TLB, model_tlb());
    endtask

    typedef struct {
        int          op;
        logic [19:0] vpn;
        logic [19:0] pfn;
        int          exp_idx;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int lat, bc, r;
        logic [19:0] rv, rp;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{OP_FILL, 20'h00010 + 20'(i), 20'h00100 + 20'(i), i};
        tbl[8]  = '{OP_FILL, 20'h00020, 20'h00200, 0};
        tbl[9]  = '{OP_FILL, 20'h00021, 20'h00201, 1};
        tbl[10] = '{OP_FILL, 20'h00013, 20'h00ABC, 3};
        tbl[11] = '{OP_INVP, 20'h00014, 20'h0, 4};
        tbl[12] = '{OP_FILL, 20'h00030, 20'h00300, 4};
        tbl[13] = '{OP_FILL, 20'h00031, 20'h00301, 2};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tlb", TLB, '0);
        check("reset_busy", 352'(busy), 352'(0));
        check("reset_acks", 352'({fill_ack, invp_ack, flush_ack}), 352'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 352'(busy), 352'(0));

        for (int i = 0; i < 14; i++)
            do_op(tbl[i].op, tbl[i].vpn, tbl[i].pfn, 3'b000, tbl[i].exp_idx, $sformatf("vec%0d", i));

        // Flush and fill raised together: flush wins, fill lands in entry 0 afterwards.
        fill_vpn = 20'h00050; fill_pfn = 20'h00500;
        {fill_present, fill_rw, fill_pcd} = 3'b101;
        fill_req = 1'b1; flush_req = 1'b1;
        wait_ack(OP_FLUSH, 20, lat, bc);
        check("ff_flush_latency", 352'(lat), 352'(8));
        check("ff_flush_busy", 352'(bc), 352'(8));
        check("ff_no_fill_ack", 352'(fill_ack), 352'(0));
        @(posedge clk); #1;
        flush_req = 1'b0;
        model_flush();
        check("ff_flushed_tlb", TLB, model_tlb());
        wait_ack(OP_FILL, 20, lat, bc);
        check("ff_fill_latency", 352'(lat), 352'(1));
        @(posedge clk); #1;
        fill_req = 1'b0;
        r = model_fill(20'h00050, 20'h00500, 3'b101);
        check("ff_fill_entry0", 352'(TLB[43:0]), 352'({20'h00050, 20'h00500, 4'b1101}));
        check("ff_fill_tlb", TLB, model_tlb());

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            rv = 20'h00040 + 20'($urandom_range(0, 11));
            rp = 20'($urandom);
            if (r == 0)
                do_op(OP_FLUSH, rv, rp, 3'b000, -1, $sformatf("rnd%0d_flush", n));
            else if (r <= 2)
                do_op(OP_INVP, rv, rp, 3'b000, -1, $sformatf("rnd%0d_invp", n));
            else
                do_op(OP_FILL, rv, rp, 3'($urandom), -1, $sformatf("rnd%0d_fill", n));
        end

        // Reset in the 4th flush cycle, then the held request restarts the flush.
        flush_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_in_flush", 352'(busy), 352'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_tlb", TLB, '0);
        check("mid_rst_busy", 352'(busy), 352'(0));
        check("mid_rst_ack", 352'(flush_ack), 352'(0));
        @(posedge clk); #1;
        check("mid_rst_held_ack", 352'(flush_ack), 352'(0));
        model_reset();
        rst = 1'b0;
        wait_ack(OP_FLUSH, 20, lat, bc);
        check("restart_flush_latency", 352'(lat), 352'(8));
        @(posedge clk); #1;
        flush_req = 1'b0;
        model_flush();
        check("restart_tlb", TLB, model_tlb());

        for (int n = 0; n < 12; n++)
            do_op(OP_FILL, 20'h00060 + 20'(n % 10), 20'($urandom), 3'($urandom), -1, $sformatf("post%0d_fill", n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_entry_ctrl.md
Name: tlb_entry_ctrl

Overview:
- Owns the 8-entry instruction TLB storage and drives the packed TLB bus that the fetch-stage TLB lookup consumes.
- Services three requesters through a small FSM: page-walk fill, single-page invalidate (INVLPG) and full flush (CR3 write).
- Selects fill victims using same-VPN overwrite, then first-invalid, then round-robin.
- Asserts busy so fetch withholds lookups while the array is being modified.

Parameters:
N_ENT, 8, number of TLB entries (design and test fixed at 8)
ENT_W, 44, bits per packed entry
VPN_W, 20, virtual/physical page number width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
fill_req  input  1  level request to write one entry; held until fill_ack
fill_vpn  input  20  virtual page number of new entry
fill_pfn  input  20  physical page number of new entry
fill_present  input  1  present bit of new entry
fill_rw  input  1  writable bit of new entry
fill_pcd  input  1  cache-disable bit of new entry
fill_ack  output  1  one-cycle pulse, fill being written this cycle
invp_req  input  1  level request to invalidate the page in invp_vpn
invp_vpn  input  20  page to invalidate
invp_ack  output  1  one-cycle pulse, invalidate performed this cycle
flush_req  input  1  level request to invalidate all entries
flush_ack  output  1  one-cycle pulse on the final flush cycle
busy  output  1  high whenever FSM is not IDLE
TLB  output  352  packed entries; entry i at [44*i+43:44*i]

Behaviour:
- Entry format:
  - [43:24] VPN
  - [23:4] PFN
  - [3] valid
  - [2] present
  - [1] rw
  - [0] pcd
- Fill writes valid=1.
- Reset (async, rst=1): all 352 TLB bits 0, state IDLE, rr_ptr=0, flush_idx=0, all acks 0, busy 0.
- FSM states:
  - IDLE, FILL, INVP, FLUSH.
  - All outputs are decoded from registered state (no combinational req->ack path).
- IDLE transitions, priority flush > invp > fill:
  - flush_req=1 -> FLUSH with flush_idx=0.
  - else invp_req=1 -> INVP.
  - else fill_req=1 -> FILL.
  - else stay in IDLE.
  - A request never jumps the queue mid-operation. Lower-priority requests stay pending and are served from IDLE after the current operation finishes.
- FILL (exactly 1 cycle):
  - fill_ack=1.
  - The victim entry is written on the closing edge, then return to IDLE.
  - Victim selection, using the current TLB contents:
    - (a) the lowest-index valid entry whose VPN equals fill_vpn (overwrite in place, rr_ptr unchanged);
    - else (b) the lowest-index entry with valid=0 (rr_ptr unchanged);
    - else (c) entry rr_ptr, then rr_ptr <= rr_ptr+1 mod 8 (wraps 7->0).
- INVP (exactly 1 cycle):
  - invp_ack=1.
  - On the closing edge, clear valid of every entry whose VPN equals invp_vpn, with valid or not. All other bits are untouched.
  - If there is no match, the TLB is unchanged and the ack is still given.
  - Return to IDLE.
- FLUSH (exactly 8 cycles, one entry per cycle):
  - Each cycle clears valid of entry flush_idx, then flush_idx increments.
  - In the cycle where flush_idx=7: flush_ack=1, rr_ptr <= 0, next state IDLE.
  - VPN/PFN/flag bits are not cleared.
- Handshake and latency:
  - A requester holds req and its data stable until it sees ack high. It deasserts on that same edge.
  - Fill latency: req sampled in IDLE at cycle 0, ack in cycle 1, new entry visible on TLB from cycle 2.
  - Invalidate latency is the same as fill.
  - Flush latency: ack in cycle 8, all valid=0 from cycle 9.
- busy is high in FILL, INVP and FLUSH. fetch must hold f_ren low while busy=1.
- Back-to-back requests:
  - A req still high in the cycle after its ack is a new request (protocol error tolerated; served again).
  - Two back-to-back fills cost 2 cycles each (IDLE+FILL).
- Reset mid-operation: FSM returns to IDLE immediately, the partially flushed or filled array is zeroed, and no ack is emitted.
- The TLB output is a direct register output with no bypass of in-flight writes.

Test Plan:
- Reset, then 8 fills with VPN 0x00010..0x00017 and PFN 0x00100..0x00107 -> entries 0..7 filled in order, each word = {VPN,PFN,4'b1000}, fill_ack one cycle after each req, rr_ptr stays 0.
- 9th fill VPN 0x00020 -> written to entry 0, rr_ptr=1. 10th fill VPN 0x00021 -> entry 1, rr_ptr=2.
- Fill VPN 0x00013 with PFN 0x00ABC while entry 3 already holds it -> entry 3 PFN becomes 0x00ABC, no other entry changes, rr_ptr unchanged.
- invp_vpn=0x00014 -> entry 4 bit[3]=0 one cycle after invp_ack. The next fill with new VPN 0x00030 goes to entry 4 (first invalid).
- flush_req and fill_req raised in the same IDLE cycle:
  - flush runs first: busy=1 for 8 cycles, flush_ack in the 8th, all valid bits 0, rr_ptr=0.
  - The fill then lands in entry 0.
- Assert rst in the 4th FLUSH cycle -> TLB all zeros immediately, busy=0, no flush_ack. The held flush_req restarts the flush after rst is released.
